// File: rtl/bnn_param_loader_if.sv
// Byte handshake, serial chain drive and readback signals of the BNN parameter loader.
// The master side is the host plus the neuron chain; the slave side is the loader.
interface bnn_param_loader_if;
  logic       start;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       setup;
  logic       param_in;
  logic       param_out;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       done;

  modport master (
    output start, data_in, data_valid, param_out,
    input  data_ready, setup, param_in, rd_data, rd_valid, busy, done
  );

  modport slave (
    input  start, data_in, data_valid, param_out,
    output data_ready, setup, param_in, rd_data, rd_valid, busy, done
  );
endinterface

// File: rtl/bnn_param_loader.sv
// Serial transmitter for the neuron weight+bias chain: bytes in, MSB-first bits out,
// with the displaced chain contents returned as a readback byte stream.
module bnn_param_loader #(
  parameter int NEURONS   = 4,
  parameter int INPUTS    = 8,
  parameter int BIAS_BITS = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  bnn_param_loader_if.slave  bus
);

  localparam int CHAIN_LEN = NEURONS * (INPUTS + BIAS_BITS);
  localparam int LW        = $clog2(CHAIN_LEN + 1);
  localparam logic [LW-1:0] CHAIN_LEN_L = LW'(CHAIN_LEN);
  localparam logic [LW-1:0] BYTE_BITS_L = LW'(8);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_BYTE = 3'd1,
    S_SHIFT     = 3'd2,
    S_FLUSH     = 3'd3,
    S_DONE      = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] bits_left_q, bits_left_d;
  logic [3:0]    nbits_q, nbits_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic [2:0]    rx_cnt_q, rx_cnt_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          setup_q;
  logic          param_in_q;
  logic          data_ready_q;
  logic          busy_q;
  logic          done_q;
  logic          accept_s;
  logic          last_bit_s;

  // Next-state, byte/bit bookkeeping and readback capture
  always_comb begin
    state_d     = state_q;
    bits_left_d = bits_left_q;
    nbits_d     = nbits_q;
    bit_cnt_d   = bit_cnt_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    rx_cnt_d    = rx_cnt_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    accept_s    = bus.data_valid & data_ready_q;
    last_bit_s  = ({1'b0, bit_cnt_q} == (nbits_q - 4'd1));

    // The chain moves on every setup edge, so the tail bit seen now is the one being lost.
    if (setup_q) begin
      rx_sh_d  = {rx_sh_q[6:0], bus.param_out};
      rx_cnt_d = rx_cnt_q + 3'd1;
      if (rx_cnt_q == 3'd7) begin
        rd_data_d  = {rx_sh_q[6:0], bus.param_out};
        rd_valid_d = 1'b1;
      end else begin
        rd_valid_d = 1'b0;
      end
    end else begin
      rx_sh_d  = rx_sh_q;
      rx_cnt_d = rx_cnt_q;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d     = S_WAIT_BYTE;
          bits_left_d = CHAIN_LEN_L;
          rx_sh_d     = 8'h00;
          rx_cnt_d    = 3'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_BYTE: begin
        if (accept_s) begin
          tx_sh_d   = bus.data_in;
          bit_cnt_d = 3'd0;
          nbits_d   = (bits_left_q >= BYTE_BITS_L) ? 4'd8 : 4'(bits_left_q);
          state_d   = S_SHIFT;
        end else begin
          state_d = S_WAIT_BYTE;
        end
      end
      S_SHIFT: begin
        tx_sh_d   = {tx_sh_q[6:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (last_bit_s) begin
          bits_left_d = bits_left_q - LW'(nbits_q);
          state_d     = (bits_left_q == LW'(nbits_q)) ? S_FLUSH : S_WAIT_BYTE;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_FLUSH: begin
        // A chain length that is not a byte multiple leaves a partial byte, sent left-justified.
        if (rx_cnt_q != 3'd0) begin
          rd_data_d  = rx_sh_q << (4'd8 - {1'b0, rx_cnt_q});
          rd_valid_d = 1'b1;
        end else begin
          rd_valid_d = 1'b0;
        end
        rx_cnt_d = 3'd0;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs, the latter derived from the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      bits_left_q  <= '0;
      nbits_q      <= 4'd0;
      bit_cnt_q    <= 3'd0;
      tx_sh_q      <= 8'h00;
      rx_sh_q      <= 8'h00;
      rx_cnt_q     <= 3'd0;
      rd_data_q    <= 8'h00;
      rd_valid_q   <= 1'b0;
      setup_q      <= 1'b0;
      param_in_q   <= 1'b0;
      data_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bits_left_q  <= bits_left_d;
      nbits_q      <= nbits_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_sh_q      <= tx_sh_d;
      rx_sh_q      <= rx_sh_d;
      rx_cnt_q     <= rx_cnt_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      setup_q      <= (state_d == S_SHIFT);
      param_in_q   <= (state_d == S_SHIFT) ? tx_sh_d[7] : 1'b0;
      data_ready_q <= (state_d == S_WAIT_BYTE);
      busy_q       <= (state_d == S_WAIT_BYTE) || (state_d == S_SHIFT) ||
                      (state_d == S_FLUSH);
      done_q       <= (state_d == S_DONE);
    end
  end

  assign bus.setup      = setup_q;
  assign bus.param_in   = param_in_q;
  assign bus.data_ready = data_ready_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_bnn_param_loader.sv
// Two loaders (1-neuron and 4-neuron chains) driven from a directed table, hand-written
// reset/restart sequences and random loads, checked against a bit-stream reference model.
module tb_bnn_param_loader;

  localparam int L0 = 11;
  localparam int L1 = 44;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bnn_param_loader_if bus0 ();
  bnn_param_loader_if bus1 ();

  bnn_param_loader #(.NEURONS(1), .INPUTS(8), .BIAS_BITS(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  bnn_param_loader #(.NEURONS(4), .INPUTS(8), .BIAS_BITS(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  logic       start_r [2];
  logic [7:0] din_r   [2];
  logic       dv_r    [2];
  logic       setup_s [2];
  logic       pin_s   [2];
  logic       rdy_s   [2];
  logic       busy_s  [2];
  logic       done_s  [2];
  logic       rdv_s   [2];
  logic [7:0] rdd_s   [2];

  assign bus0.start = start_r[0];  assign bus1.start = start_r[1];
  assign bus0.data_in = din_r[0];  assign bus1.data_in = din_r[1];
  assign bus0.data_valid = dv_r[0]; assign bus1.data_valid = dv_r[1];
  assign setup_s[0] = bus0.setup;  assign setup_s[1] = bus1.setup;
  assign pin_s[0] = bus0.param_in; assign pin_s[1] = bus1.param_in;
  assign rdy_s[0] = bus0.data_ready; assign rdy_s[1] = bus1.data_ready;
  assign busy_s[0] = bus0.busy;    assign busy_s[1] = bus1.busy;
  assign done_s[0] = bus0.done;    assign done_s[1] = bus1.done;
  assign rdv_s[0] = bus0.rd_valid; assign rdv_s[1] = bus1.rd_valid;
  assign rdd_s[0] = bus0.rd_data;  assign rdd_s[1] = bus1.rd_data;

  // Neuron chain stand-in: bit 0 is neuron 0 weights[0], bit L-1 is the tail.
  logic [43:0] chain_q [2] = '{44'd0, 44'd0};
  always @(posedge clk) begin
    if (bus0.setup) chain_q[0] <= {chain_q[0][42:0], bus0.param_in};
    if (bus1.setup) chain_q[1] <= {chain_q[1][42:0], bus1.param_in};
  end
  assign bus0.param_out = chain_q[0][L0-1];
  assign bus1.param_out = chain_q[1][L1-1];

  logic       sent_b [2][1024];
  logic [7:0] rd_b   [2][256];
  int sent_n [2] = '{0, 0};
  int rd_n   [2] = '{0, 0};
  int acc_n  [2] = '{0, 0};
  int done_n [2] = '{0, 0};
  int bad_n  [2] = '{0, 0};

  // Mid-cycle monitor: records shifted bits, readback bytes, handshakes and illegal combos
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (setup_s[i] && sent_n[i] < 1024) begin
        sent_b[i][sent_n[i]] <= pin_s[i];
        sent_n[i] <= sent_n[i] + 1;
      end
      if (rdv_s[i] && rd_n[i] < 256) begin
        rd_b[i][rd_n[i]] <= rdd_s[i];
        rd_n[i] <= rd_n[i] + 1;
      end
      if (dv_r[i] && rdy_s[i]) acc_n[i] <= acc_n[i] + 1;
      if (done_s[i]) done_n[i] <= done_n[i] + 1;
      if ((setup_s[i] && !busy_s[i]) || (done_s[i] && busy_s[i]) || (rdy_s[i] && !busy_s[i]))
        bad_n[i] <= bad_n[i] + 1;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One full load; pk holds the bytes with byte 0 in bits [63:56].
  task automatic do_load(input int i, input logic [63:0] pk, input int nb, input int gap,
                         input bit hold, input bit restart, input string tag);
    int t, len, s0, r0, a0, d0, b0, tmo, gap_bad;
    logic [43:0] snap;
    logic [63:0] exp_s, exp_r, act_s, act_c, act_r;
    len = (i == 0) ? L0 : L1;
    snap = chain_q[i];
    s0 = sent_n[i]; r0 = rd_n[i]; a0 = acc_n[i]; d0 = done_n[i]; b0 = bad_n[i];
    tmo = 0; gap_bad = 0;
    @(posedge clk); #1 start_r[i] = 1'b1;
    @(posedge clk); #1 start_r[i] = 1'b0;
    chk($sformatf("%s_busy_rdy_after_start", tag), {62'd0, busy_s[i], rdy_s[i]}, 64'd3);
    for (int k = 0; k < nb; k++) begin
      if (gap > 0 && k > 0) begin
        dv_r[i] = 1'b0; t = 0;
        while (!rdy_s[i] && t < 100) begin @(posedge clk); #1; t++; end
        for (int g = 0; g < gap; g++) begin
          if (setup_s[i]) gap_bad++;
          @(posedge clk); #1;
        end
      end
      din_r[i] = pk[63-8*k -: 8];
      dv_r[i]  = 1'b1;
      t = 0;
      while (!rdy_s[i] && t < 100) begin @(posedge clk); #1; t++; end
      if (t >= 100) tmo++;
      @(posedge clk); #1;
      if (!hold) dv_r[i] = 1'b0;
      if (restart && k == 1) begin
        start_r[i] = 1'b1;
        @(posedge clk); #1 start_r[i] = 1'b0;
      end
    end
    t = 0;
    while (done_n[i] == d0 && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) tmo++;
    repeat (3) begin @(posedge clk); #1; end
    dv_r[i] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Reference: the chain ends up holding the first len bits of the byte stream
    // (first bit at the tail), and readback returns the old chain tail-first.
    exp_s = pk & ~(64'hFFFF_FFFF_FFFF_FFFF >> len);
    exp_r = 64'd0; act_s = 64'd0; act_c = 64'd0; act_r = 64'd0;
    for (int k = 0; k < len; k++) begin
      exp_r[63-k] = snap[len-1-k];
      act_c[63-k] = chain_q[i][len-1-k];
      if (s0 + k < 1024) act_s[63-k] = sent_b[i][s0+k];
    end
    for (int m = 0; m < (len + 7) / 8 && m < rd_n[i] - r0; m++)
      act_r[63-8*m -: 8] = rd_b[i][r0+m];

    chk($sformatf("%s_timeout", tag), 64'(tmo), 64'd0);
    chk($sformatf("%s_gap_setup", tag), 64'(gap_bad), 64'd0);
    chk($sformatf("%s_setup_pulses", tag), 64'(sent_n[i] - s0), 64'(len));
    chk($sformatf("%s_bytes_accepted", tag), 64'(acc_n[i] - a0), 64'((len + 7) / 8));
    chk($sformatf("%s_rd_pulses", tag), 64'(rd_n[i] - r0), 64'((len + 7) / 8));
    chk($sformatf("%s_done_pulses", tag), 64'(done_n[i] - d0), 64'd1);
    chk($sformatf("%s_illegal_outputs", tag), 64'(bad_n[i] - b0), 64'd0);
    chk($sformatf("%s_param_in_stream", tag), act_s, exp_s);
    chk($sformatf("%s_chain", tag), act_c, exp_s);
    chk($sformatf("%s_readback", tag), act_r, exp_r);
  endtask

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    int         gap;
    logic       hold;
    logic [2:0] bias;
    logic [7:0] w;
    logic [7:0] rd0;
    logic [7:0] rd1;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int r0;
    logic [63:0] pk;
    tbl[0] = '{8'hA5, 8'hE0, 0, 1'b0, 3'b101, 8'h2F, 8'h00, 8'h00};
    tbl[1] = '{8'h00, 8'h00, 0, 1'b1, 3'b000, 8'h00, 8'hA5, 8'hE0};
    tbl[2] = '{8'hA5, 8'hE0, 5, 1'b0, 3'b101, 8'h2F, 8'h00, 8'h00};
    tbl[3] = '{8'h3C, 8'h5F, 2, 1'b1, 3'b001, 8'hE2, 8'hA5, 8'hE0};
    tbl[4] = '{8'hFF, 8'h1F, 0, 1'b0, 3'b111, 8'hF8, 8'h3C, 8'h40};
    for (int i = 0; i < 2; i++) begin
      start_r[i] = 1'b0; din_r[i] = 8'h00; dv_r[i] = 1'b0;
    end

    #12;
    chk("reset_outputs_n1", {52'd0, bus0.setup, bus0.param_in, bus0.data_ready, bus0.busy,
        bus0.done, bus0.rd_valid, bus0.rd_data[5:0]} | {56'd0, bus0.rd_data}, 64'd0);
    chk("reset_outputs_n4", {52'd0, bus1.setup, bus1.param_in, bus1.data_ready, bus1.busy,
        bus1.done, bus1.rd_valid, bus1.rd_data[5:0]} | {56'd0, bus1.rd_data}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Directed single-neuron table: field decode and readback of the previous entry
    for (int v = 0; v < 5; v++) begin
      r0 = rd_n[0];
      do_load(0, {tbl[v].b0, tbl[v].b1, 48'd0}, 2, tbl[v].gap, tbl[v].hold, 1'b0,
              $sformatf("tbl%0d", v));
      chk($sformatf("tbl%0d_bias", v), 64'(chain_q[0][10:8]), 64'(tbl[v].bias));
      chk($sformatf("tbl%0d_weights", v), 64'(chain_q[0][7:0]), 64'(tbl[v].w));
      chk($sformatf("tbl%0d_rd0", v), 64'(rd_b[0][r0]), 64'(tbl[v].rd0));
      chk($sformatf("tbl%0d_rd1", v), 64'(rd_b[0][r0+1]), 64'(tbl[v].rd1));
    end

    // Reset after three shifted bits, then a clean reload
    begin
      int s0, t;
      s0 = sent_n[0];
      @(posedge clk); #1 start_r[0] = 1'b1;
      @(posedge clk); #1 start_r[0] = 1'b0; din_r[0] = 8'hA5; dv_r[0] = 1'b1;
      t = 0;
      while (sent_n[0] - s0 < 3 && t < 100) begin @(negedge clk); #1; t++; end
      chk("rst_reach_three_bits", 64'(sent_n[0] - s0), 64'd3);
      @(posedge clk); #1 rst_n = 1'b0; dv_r[0] = 1'b0;
      #1;
      chk("rst_mid_setup", 64'(bus0.setup), 64'd0);
      chk("rst_mid_busy", 64'(bus0.busy), 64'd0);
      chk("rst_mid_ready", 64'(bus0.data_ready), 64'd0);
      repeat (2) @(posedge clk);
      #1 chk("rst_mid_chain", 64'(chain_q[0][10:0]), 64'h7C5);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_idle_after_release", {62'd0, bus0.busy, bus0.data_ready}, 64'd0);
      do_load(0, {8'hA5, 8'hE0, 48'd0}, 2, 0, 1'b0, 1'b0, "after_rst");
      chk("after_rst_bias", 64'(chain_q[0][10:8]), 64'd5);
      chk("after_rst_weights", 64'(chain_q[0][7:0]), 64'h2F);
    end

    // Four-neuron chain: restart while busy, continuous valid, then random loads
    do_load(1, {8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 16'd0}, 6, 0, 1'b0, 1'b1, "n4_restart");
    chk("n4_neuron3_bias", 64'(chain_q[1][43:41]), 64'd0);
    chk("n4_neuron0_weights", 64'(chain_q[1][7:0]), 64'hAB);
    do_load(1, {8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hF7, 16'd0}, 6, 0, 1'b1, 1'b0, "n4_hold");
    for (int n = 0; n < 6; n++) begin
      pk = {$urandom, $urandom};
      pk[15:0] = 16'd0;
      do_load(1, pk, 6, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'(n % 2),
              $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
